// File: rtl/sha256_nonce_search_ctrl.sv
// Nonce search sequencer for one external single-block SHA-256 core.
// Ports: cfg_* request (valid/ready), abort, core_* launch/result,
//        busy/done/found/aborted/timeout_err status, result_* and attempts.
module sha256_nonce_search_ctrl #(
   parameter int unsigned NONCE_W   = 32,
   parameter int unsigned NONCE_LSB = 0,
   parameter int unsigned TIMEOUT   = 127
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [511:0]       cfg_message,
   input  logic [NONCE_W-1:0] cfg_nonce_first,
   input  logic [NONCE_W-1:0] cfg_nonce_last,
   input  logic [255:0]       cfg_target,
   input  logic               abort,
   output logic               core_start,
   output logic [511:0]       core_message,
   input  logic [255:0]       core_hash,
   input  logic               core_ready,
   output logic               busy,
   output logic               done,
   output logic               found,
   output logic               aborted,
   output logic               timeout_err,
   output logic [NONCE_W-1:0] result_nonce,
   output logic [255:0]       result_hash,
   output logic [31:0]        attempts
);

   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_WAIT, S_CHECK, S_DONE
   } state_e;

   localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

   state_e             state_q, state_d;
   logic [511:0]       msg_q, msg_d;
   logic [NONCE_W-1:0] last_q, last_d;
   logic [255:0]       target_q, target_d;
   logic [NONCE_W-1:0] nonce_q, nonce_d;
   logic [31:0]        wdog_q, wdog_d;
   logic [31:0]        att_q, att_d;
   logic               found_q, found_d;
   logic               abt_q, abt_d;
   logic               tmo_q, tmo_d;
   logic [NONCE_W-1:0] rn_q, rn_d;
   logic [255:0]       rh_q, rh_d;

   logic accept, hit, at_last, wd_exp;

   assign accept  = cfg_valid & (state_q == S_IDLE);
   assign hit     = rh_q <= target_q;
   assign at_last = nonce_q == last_q;
   // Last WAIT cycle allowed before the watchdog fires.
   assign wd_exp  = wdog_q == WD_LAST;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next state; abort outranks every other exit
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (accept) state_d = S_LAUNCH;
         S_LAUNCH: state_d = abort ? S_DONE : S_WAIT;
         S_WAIT: begin
            if (abort)           state_d = S_DONE;
            else if (core_ready) state_d = S_CHECK;
            else if (wd_exp)     state_d = S_DONE;
         end
         S_CHECK: begin
            if (abort || hit || at_last) state_d = S_DONE;
            else                         state_d = S_LAUNCH;
         end
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      cfg_ready  = state_q == S_IDLE;
      busy       = state_q != S_IDLE;
      core_start = state_q == S_LAUNCH;
      done       = state_q == S_DONE;
      core_message = msg_q;
      core_message[NONCE_LSB +: NONCE_W] = nonce_q;
   end

   assign found        = found_q;
   assign aborted      = abt_q;
   assign timeout_err  = tmo_q;
   assign result_nonce = rn_q;
   assign result_hash  = rh_q;
   assign attempts     = att_q;

   // Datapath next-state
   always_comb begin
      msg_d    = msg_q;
      last_d   = last_q;
      target_d = target_q;
      nonce_d  = nonce_q;
      wdog_d   = wdog_q;
      att_d    = att_q;
      found_d  = found_q;
      abt_d    = abt_q;
      tmo_d    = tmo_q;
      rn_d     = rn_q;
      rh_d     = rh_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               msg_d    = cfg_message;
               last_d   = cfg_nonce_last;
               target_d = cfg_target;
               nonce_d  = cfg_nonce_first;
               att_d    = '0;
               found_d  = 1'b0;
               abt_d    = 1'b0;
               tmo_d    = 1'b0;
            end
         end
         S_LAUNCH: begin
            wdog_d = '0;
            if (abort) abt_d = 1'b1;
         end
         S_WAIT: begin
            wdog_d = wdog_q + 32'd1;
            if (abort) begin
               abt_d = 1'b1;
            end else if (core_ready) begin
               rh_d = core_hash;
               rn_d = nonce_q;
            end else if (wd_exp) begin
               tmo_d = 1'b1;
            end
         end
         S_CHECK: begin
            if (abort) begin
               abt_d = 1'b1;
            end else begin
               att_d = (&att_q) ? att_q : att_q + 32'd1;
               if (hit)           found_d = 1'b1;
               else if (!at_last) nonce_d = nonce_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         msg_q    <= '0;
         last_q   <= '0;
         target_q <= '0;
         nonce_q  <= '0;
         wdog_q   <= '0;
         att_q    <= '0;
         found_q  <= 1'b0;
         abt_q    <= 1'b0;
         tmo_q    <= 1'b0;
         rn_q     <= '0;
         rh_q     <= '0;
      end else begin
         msg_q    <= msg_d;
         last_q   <= last_d;
         target_q <= target_d;
         nonce_q  <= nonce_d;
         wdog_q   <= wdog_d;
         att_q    <= att_d;
         found_q  <= found_d;
         abt_q    <= abt_d;
         tmo_q    <= tmo_d;
         rn_q     <= rn_d;
         rh_q     <= rh_d;
      end
   end

endmodule

// File: tb/tb_sha256_nonce_search_ctrl.sv
// Bench for sha256_nonce_search_ctrl: stub SHA core with fixed latency,
// scoreboard queues for issued nonces and end-of-search results.
module tb_sha256_nonce_search_ctrl;

   localparam int LSB = 0;

   logic         clk, rst;
   logic         cfg_valid, cfg_ready;
   logic [511:0] cfg_message;
   logic [31:0]  cfg_nonce_first, cfg_nonce_last;
   logic [255:0] cfg_target;
   logic         abort;
   logic         core_start;
   logic [511:0] core_message;
   logic [255:0] core_hash;
   logic         core_ready;
   logic         busy, done, found, aborted, timeout_err;
   logic [31:0]  result_nonce;
   logic [255:0] result_hash;
   logic [31:0]  attempts;

   sha256_nonce_search_ctrl #(
      .NONCE_W(32), .NONCE_LSB(LSB), .TIMEOUT(127)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_message(cfg_message),
      .cfg_nonce_first(cfg_nonce_first),
      .cfg_nonce_last(cfg_nonce_last),
      .cfg_target(cfg_target), .abort(abort),
      .core_start(core_start), .core_message(core_message),
      .core_hash(core_hash), .core_ready(core_ready),
      .busy(busy), .done(done), .found(found),
      .aborted(aborted), .timeout_err(timeout_err),
      .result_nonce(result_nonce), .result_hash(result_hash),
      .attempts(attempts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         f, a, t;
      logic [31:0]  rn;
      logic         crn;
      logic [31:0]  att;
      logic [255:0] rh;
      logic         crh;
   } exp_t;

   exp_t         res_q[$];
   logic [31:0]  nonce_q[$];
   logic [511:0] cur_msg;
   logic [511:0] nmask;
   int           n_checks = 0;
   int           n_fail = 0;
   int           n_starts = 0;

   // stub core controls
   int           stub_lat = 3;
   logic         stub_never = 1'b0;
   logic [31:0]  hit_nonce = 32'hDEAD_0000;
   logic         abt_en = 1'b0;
   logic [31:0]  abt_nonce = '0;

   task automatic chk(input string tag, input logic [255:0] got,
                      input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push_res(input logic f, a, t, input logic [31:0] rn,
                           input logic crn, input logic [31:0] att,
                           input logic [255:0] rh, input logic crh);
      exp_t e;
      e.f = f; e.a = a; e.t = t; e.rn = rn; e.crn = crn;
      e.att = att; e.rh = rh; e.crh = crh;
      res_q.push_back(e);
   endtask

   // Stub core: core_ready stub_lat cycles after core_start
   initial begin
      int cnt;
      logic [31:0] nf;
      cnt = 0;
      core_ready = 1'b0;
      core_hash = '0;
      abort = 1'b0;
      forever begin
         @(negedge clk);
         core_ready = 1'b0;
         abort = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0 && !stub_never) begin
               nf = core_message[LSB +: 32];
               core_ready = 1'b1;
               core_hash = (nf == hit_nonce) ? 256'd0 : 256'd1;
               if (abt_en && nf == abt_nonce) abort = 1'b1;
            end
         end
         if (core_start) cnt = stub_lat;
      end
   end

   // Monitor / scoreboard
   initial begin
      logic [31:0] en;
      exp_t e;
      forever begin
         @(negedge clk);
         if (core_start) begin
            n_starts++;
            if (nonce_q.size() == 0) begin
               chk("extra_start", 1, 0);
            end else begin
               en = nonce_q.pop_front();
               chk("start_nonce", core_message[LSB +: 32], en);
               chk("msg_tmpl",
                   256'(((core_message ^ cur_msg) & ~nmask) == '0), 1);
            end
         end
         if (done) begin
            if (res_q.size() == 0) begin
               chk("extra_done", 1, 0);
            end else begin
               e = res_q.pop_front();
               chk("found", found, e.f);
               chk("aborted", aborted, e.a);
               chk("timeout_err", timeout_err, e.t);
               chk("attempts", attempts, e.att);
               if (e.crn) chk("result_nonce", result_nonce, e.rn);
               if (e.crh) chk("result_hash", result_hash, e.rh);
            end
         end
      end
   end

   task automatic start_search(input logic [31:0] f, l,
                               input logic [255:0] t);
      for (int i = 0; i < 16; i++) cur_msg[i*32 +: 32] = $urandom;
      cfg_message = cur_msg;
      cfg_nonce_first = f;
      cfg_nonce_last = l;
      cfg_target = t;
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int n = 0;
      while (!done && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk("done_wait", 0, 1);
      @(negedge clk);
   endtask

   task automatic wait_start(input int bound);
      int n = 0;
      while (!core_start && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (!core_start) chk("start_wait", 0, 1);
   endtask

   initial begin
      int n;
      nmask = 512'(32'hFFFF_FFFF) << LSB;
      cur_msg = '0;
      rst = 1'b0;
      cfg_valid = 1'b0;
      cfg_message = '0;
      cfg_nonce_first = '0;
      cfg_nonce_last = '0;
      cfg_target = '0;
      #3 rst = 1'b1;
      #1;
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_start", core_start, 0);
      chk("rst_attempts", attempts, 0);
      chk("rst_hash", result_hash, 0);
      chk("rst_msg", 256'(core_message == '0), 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 1: target all-ones, first nonce hits
      nonce_q.push_back(5);
      push_res(1, 0, 0, 5, 1, 1, 256'd1, 1);
      start_search(5, 9, '1);
      wait_done(200);

      // 2: hit at nonce 7
      hit_nonce = 7;
      nonce_q.push_back(5); nonce_q.push_back(6); nonce_q.push_back(7);
      push_res(1, 0, 0, 7, 1, 3, 256'd0, 1);
      start_search(5, 9, '0);
      wait_done(200);

      // 3: range wraps through zero, no hit
      nonce_q.push_back(32'hFFFF_FFFE); nonce_q.push_back(32'hFFFF_FFFF);
      nonce_q.push_back(0); nonce_q.push_back(1);
      push_res(0, 0, 0, 1, 1, 4, 256'd1, 1);
      start_search(32'hFFFF_FFFE, 1, '0);
      wait_done(200);

      // 4: core never answers -> watchdog
      stub_never = 1'b1;
      nonce_q.push_back(3);
      push_res(0, 0, 1, 0, 0, 0, 0, 0);
      start_search(3, 8, '0);
      wait_start(20);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 400);
      chk("t4_latency", n, 128);
      @(negedge clk);
      stub_never = 1'b0;

      // 5: abort together with the hit of the 3rd nonce
      hit_nonce = 22;
      abt_en = 1'b1;
      abt_nonce = 22;
      nonce_q.push_back(20); nonce_q.push_back(21); nonce_q.push_back(22);
      push_res(0, 1, 0, 21, 1, 2, 256'd1, 1);
      start_search(20, 30, '0);
      cfg_nonce_first = 99;
      cfg_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("cfg_ready_busy", cfg_ready, 0);
      end
      cfg_valid = 1'b0;
      wait_done(200);
      abt_en = 1'b0;
      repeat (6) @(negedge clk);
      chk("t5_no_more", nonce_q.size(), 0);

      // 6: reset mid-WAIT, stale core_ready, then a fresh search
      hit_nonce = 32'hDEAD_0000;
      nonce_q.push_back(40);
      start_search(40, 50, '0);
      wait_start(20);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_cfg_ready", cfg_ready, 1);
      chk("t6_start", core_start, 0);
      chk("t6_found", found, 0);
      chk("t6_attempts", attempts, 0);
      chk("t6_rnonce", result_nonce, 0);
      chk("t6_msg", 256'(core_message == '0), 1);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      hit_nonce = 61;
      nonce_q.push_back(60); nonce_q.push_back(61);
      push_res(1, 0, 0, 61, 1, 2, 256'd0, 1);
      start_search(60, 70, '0);
      wait_done(200);

      repeat (4) @(negedge clk);
      chk("nonce_q_empty", nonce_q.size(), 0);
      chk("res_q_empty", res_q.size(), 0);
      chk("total_starts", n_starts, 15);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
